adxl362_burst_ctrl: RTL

//  SPI mode-0 master for the ADXL362 accelerometer with multi-byte burst transfers.

---
 rtl/adxl362_pkg.sv | 41 ++++
 rtl/adxl362_burst_ctrl_shifter.sv | 33 +++
 rtl/adxl362_burst_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/adxl362_pkg.sv
// Shared constants and types for the ADXL362 burst SPI controller.
package adxl362_pkg;

    // SPI instruction bytes understood by the ADXL362
    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_FIFO  = 8'h0D;

    // Frequently used register addresses and keys
    localparam logic [7:0] REG_DEVID_AD   = 8'h00;
    localparam logic [7:0] REG_PARTID     = 8'h02;
    localparam logic [7:0] REG_STATUS     = 8'h0B;
    localparam logic [7:0] REG_SOFT_RESET = 8'h1F;
    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

    // Operation selector as presented on the cmd port
    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_FIFO  = 2'd2,
        OP_RSVD  = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Instruction byte for an operation; the reserved code behaves as a read.
    function automatic logic [7:0] cmd_to_byte(input cmd_e op);
        case (op)
            OP_WRITE: return CMD_WRITE;
            OP_FIFO:  return CMD_FIFO;
            default:  return CMD_READ;
        endcase
    endfunction

endpackage

// File: rtl/adxl362_burst_ctrl_shifter.sv
// One-byte SPI shift register: MSB-first transmit, MSB-first receive.
// The parent supplies one-cycle strobes marking SCLK rising and falling edges.
module spi_byte_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       sclk_rise,
    input  logic       sclk_fall,
    input  logic       miso,
    output logic       mosi,
    output logic [7:0] rx_byte
);

    logic [7:0] tx_sh;

    // Transmit register: a load wins over a shift so the next byte can be
    // loaded on the same falling edge that completes the current one.
    always_ff @(posedge clk) begin
        if (rst)            tx_sh <= 8'h00;
        else if (load)      tx_sh <= load_byte;
        else if (sclk_fall) tx_sh <= {tx_sh[6:0], 1'b0};
    end

    // Receive register: MISO is captured on each SCLK rising edge.
    always_ff @(posedge clk) begin
        if (rst)            rx_byte <= 8'h00;
        else if (sclk_rise) rx_byte <= {rx_byte[6:0], miso};
    end

    assign mosi = tx_sh[7];

endmodule

// File: rtl/adxl362_burst_ctrl.sv
// SPI mode-0 master for the ADXL362 issuing cmd, optional address and a burst
// of 1..MAX_BYTES data bytes under a single chip-select assertion.
// Handshake: start is only looked at in IDLE; busy covers CS_SETUP..CS_HOLD,
// and done pulses for one cycle in DONE when the transaction is complete.
module adxl362_burst_ctrl
    import adxl362_pkg::*;
#(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int SCLK_FREQUENCY = 1_000_000,
    parameter int MAX_BYTES      = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [1:0]                     cmd,
    input  logic [7:0]                     addr,
    input  logic [$clog2(MAX_BYTES+1)-1:0] len,
    input  logic [8*MAX_BYTES-1:0]         wdata,
    output logic [8*MAX_BYTES-1:0]         rdata,
    output logic                           busy,
    output logic                           done,
    output logic                           sclk,
    output logic                           cs_n,
    output logic                           mosi,
    input  logic                           miso,
    output state_e                         state
);

    localparam int HALF = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int LW   = $clog2(MAX_BYTES + 1);
    localparam int BW   = 5;

    state_e                 state_d;
    cmd_e                   op_q;
    logic [7:0]             addr_q;
    logic [8*MAX_BYTES-1:0] wdata_q;
    logic [BW-1:0]          n_q;
    logic [DW-1:0]          div_cnt;
    logic                   phase;
    logic [2:0]             bit_cnt;
    logic [BW-1:0]          byte_cnt;
    logic [BW-1:0]          hdr, last_byte, next_byte, next_idx, cur_idx;
    logic                   accept, div_end, rise, fall, byte_end, frame_end;
    logic                   load;
    logic [7:0]             load_byte;
    logic [7:0]             rx_byte;

    // Clamp the requested length into 1..MAX_BYTES.
    function automatic logic [BW-1:0] clamp_len(input logic [LW-1:0] l);
        if (l == '0)                 return BW'(1);
        else if (int'(l) > MAX_BYTES) return BW'(MAX_BYTES);
        else                         return BW'(l);
    endfunction

    assign hdr       = (op_q == OP_FIFO) ? BW'(1) : BW'(2);
    assign last_byte = hdr + n_q - BW'(1);
    assign next_byte = byte_cnt + BW'(1);
    assign next_idx  = next_byte - hdr;
    assign cur_idx   = byte_cnt - hdr;
    assign accept    = (state == ST_IDLE) && start;
    assign div_end   = (div_cnt == DW'(HALF - 1));
    assign rise      = (state == ST_SHIFT) && div_end && !phase;
    assign fall      = (state == ST_SHIFT) && div_end && phase;
    assign byte_end  = fall && (bit_cnt == 3'd7);
    assign frame_end = byte_end && (byte_cnt == last_byte);
    assign load      = accept || byte_end;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // Next-state and chip-select/status decode.
    always_comb begin
        state_d = state;
        busy    = 1'b0;
        done    = 1'b0;
        cs_n    = 1'b1;
        case (state)
            ST_IDLE:     if (start) state_d = ST_CS_SETUP;
            ST_CS_SETUP: begin
                busy = 1'b1;
                cs_n = 1'b0;
                if (div_end) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                cs_n = 1'b0;
                if (frame_end) state_d = ST_CS_HOLD;
            end
            ST_CS_HOLD: begin
                busy = 1'b1;
                cs_n = 1'b0;
                if (div_end) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte to place in the shifter: command at start, then address, then
    // write data; reads and the tail of the frame shift out zeros.
    always_comb begin
        load_byte = 8'h00;
        if (state == ST_IDLE) begin
            load_byte = cmd_to_byte(cmd_e'(cmd));
        end else if (hdr == BW'(2) && next_byte == BW'(1)) begin
            load_byte = addr_q;
        end else if (op_q == OP_WRITE) begin
            for (int i = 0; i < MAX_BYTES; i++)
                if (BW'(i) == next_idx) load_byte = wdata_q[8*i +: 8];
        end
    end

    // Input latching, SCLK divider, bit/byte counters and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_WRITE;
            addr_q   <= 8'h00;
            wdata_q  <= '0;
            n_q      <= BW'(1);
            div_cnt  <= '0;
            phase    <= 1'b0;
            bit_cnt  <= 3'd0;
            byte_cnt <= '0;
            sclk     <= 1'b0;
            rdata    <= '0;
        end else if (accept) begin
            op_q     <= cmd_e'(cmd);
            addr_q   <= addr;
            wdata_q  <= wdata;
            n_q      <= clamp_len(len);
            div_cnt  <= '0;
            phase    <= 1'b0;
            bit_cnt  <= 3'd0;
            byte_cnt <= '0;
            sclk     <= 1'b0;
        end else if (state == ST_CS_SETUP || state == ST_CS_HOLD) begin
            div_cnt <= div_end ? '0 : div_cnt + 1'b1;
        end else if (state == ST_SHIFT) begin
            div_cnt <= div_end ? '0 : div_cnt + 1'b1;
            if (rise) begin
                sclk  <= 1'b1;
                phase <= 1'b1;
            end
            if (fall) begin
                sclk    <= 1'b0;
                phase   <= 1'b0;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7 && !frame_end) byte_cnt <= next_byte;
            end
            // A completed data byte of a read lands in its rdata slot.
            if (byte_end && op_q != OP_WRITE && byte_cnt >= hdr) begin
                for (int i = 0; i < MAX_BYTES; i++)
                    if (BW'(i) == cur_idx) rdata[8*i +: 8] <= rx_byte;
            end
        end
    end

    spi_byte_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_byte (load_byte),
        .sclk_rise (rise),
        .sclk_fall (fall),
        .miso      (miso),
        .mosi      (mosi),
        .rx_byte   (rx_byte)
    );

endmodule
